// File: rtl/ps2_mouse_init.sv
// ps2_mouse_init: host-side PS/2 mouse bring-up sequencer.
// Sends FF (reset), checks FA/AA/00, sends F4 (enable streaming) and checks FA.
// After that, good receive bytes are forwarded to the packet decoder.
// A bad byte, a receive error or a timeout restarts the sequence, up to
// MAX_RETRY times; after that the block parks in S_ERROR.
// Optional macro PS2_SET_RATE_EN adds F3 / 64 (100 samples/s) between the
// ID check and the enable command. Each of these has its own TX wait and FA check.
module ps2_mouse_init #(
  parameter logic [25:0] TIMEOUT_CYC = 26'd50_000_000,
  parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       start,
  output logic       tx_wr_en,
  output logic [7:0] tx_wr_data,
  input  logic       tx_wr_done,
  input  logic       rx_vld,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       init_done,
  output logic       init_err,
  output logic       stream_vld,
  output logic [7:0] stream_data,
  output logic [1:0] retry_cnt
);

  typedef enum logic [4:0] {
    S_IDLE, S_SEND_RST, S_TXW_RST, S_ACK_RST, S_BAT, S_ID,
`ifdef PS2_SET_RATE_EN
    S_SEND_SR, S_TXW_SR, S_ACK_SR, S_SEND_RT, S_TXW_RT, S_ACK_RT,
`endif
    S_SEND_EN, S_TXW_EN, S_ACK_EN, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d, ok_state;
  logic [25:0] tmo_q;
  logic [1:0]  retry_q, retry_d;
  logic        done_q, done_d, err_q, err_d;
  logic        svld_q, svld_d;
  logic [7:0]  sdata_q, sdata_d;
  logic        txen_q, send_d;
  logic [7:0]  txdata_q, cmd_d;
  logic        txw, rxc, tmo_hit, fail;
  logic [7:0]  exp_byte;

  // Next-state logic. Each wait state names the event it waits for and the
  // state it moves to on success. Failure handling is shared by all wait states.
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    done_d   = done_q;
    err_d    = err_q;
    svld_d   = 1'b0;
    sdata_d  = sdata_q;
    txw      = 1'b0;
    rxc      = 1'b0;
    fail     = 1'b0;
    exp_byte = 8'h00;
    ok_state = state_q;
    case (state_q)
      S_IDLE:     state_d = S_SEND_RST;
      S_SEND_RST: state_d = S_TXW_RST;
      S_TXW_RST:  begin txw = 1'b1; ok_state = S_ACK_RST; end
      S_ACK_RST:  begin rxc = 1'b1; exp_byte = 8'hFA; ok_state = S_BAT; end
      S_BAT:      begin rxc = 1'b1; exp_byte = 8'hAA; ok_state = S_ID; end
`ifdef PS2_SET_RATE_EN
      S_ID:       begin rxc = 1'b1; exp_byte = 8'h00; ok_state = S_SEND_SR; end
      S_SEND_SR:  state_d = S_TXW_SR;
      S_TXW_SR:   begin txw = 1'b1; ok_state = S_ACK_SR; end
      S_ACK_SR:   begin rxc = 1'b1; exp_byte = 8'hFA; ok_state = S_SEND_RT; end
      S_SEND_RT:  state_d = S_TXW_RT;
      S_TXW_RT:   begin txw = 1'b1; ok_state = S_ACK_RT; end
      S_ACK_RT:   begin rxc = 1'b1; exp_byte = 8'hFA; ok_state = S_SEND_EN; end
`else
      S_ID:       begin rxc = 1'b1; exp_byte = 8'h00; ok_state = S_SEND_EN; end
`endif
      S_SEND_EN:  state_d = S_TXW_EN;
      S_TXW_EN:   begin txw = 1'b1; ok_state = S_ACK_EN; end
      S_ACK_EN:   begin rxc = 1'b1; exp_byte = 8'hFA; ok_state = S_DONE; end
      S_DONE: begin
        // A byte that arrives with start is dropped; the stream is being torn down.
        if (start) begin
          state_d = S_SEND_RST;
          done_d  = 1'b0;
          retry_d = 2'd0;
        end else if (rx_vld && !rx_err) begin
          svld_d  = 1'b1;
          sdata_d = rx_data;
        end
      end
      S_ERROR: begin
        if (start) begin
          state_d = S_SEND_RST;
          err_d   = 1'b0;
          retry_d = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A timeout counts only when no qualifying event arrives in the same cycle.
    tmo_hit = (txw || rxc) && (tmo_q == TIMEOUT_CYC - 26'd1);
    if (txw) begin
      if (tx_wr_done)   state_d = ok_state;
      else if (tmo_hit) fail = 1'b1;
    end
    if (rxc) begin
      if (rx_vld) begin
        if (!rx_err && rx_data == exp_byte) state_d = ok_state;
        else                                fail = 1'b1;
      end else if (tmo_hit) begin
        fail = 1'b1;
      end
    end

    if (fail) begin
      if (retry_q < MAX_RETRY) begin
        retry_d = retry_q + 2'd1;
        state_d = S_SEND_RST;
      end else begin
        state_d = S_ERROR;
        err_d   = 1'b1;
      end
    end

    if (state_d == S_DONE && state_q != S_DONE) done_d = 1'b1;

    // The write strobe is registered so that it is high exactly while in S_SEND_*.
    send_d = 1'b1;
    cmd_d  = txdata_q;
    case (state_d)
      S_SEND_RST: cmd_d = 8'hFF;
`ifdef PS2_SET_RATE_EN
      S_SEND_SR:  cmd_d = 8'hF3;
      S_SEND_RT:  cmd_d = 8'h64;
`endif
      S_SEND_EN:  cmd_d = 8'hF4;
      default:    send_d = 1'b0;
    endcase
  end

  // State, timeout counter and registered outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      retry_q  <= 2'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      svld_q   <= 1'b0;
      sdata_q  <= 8'h00;
      txen_q   <= 1'b0;
      txdata_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      done_q   <= done_d;
      err_q    <= err_d;
      svld_q   <= svld_d;
      sdata_q  <= sdata_d;
      txen_q   <= send_d;
      txdata_q <= cmd_d;
      if (state_d != state_q) tmo_q <= '0;
      else if (txw || rxc)    tmo_q <= tmo_q + 26'd1;
    end
  end

  assign tx_wr_en    = txen_q;
  assign tx_wr_data  = txdata_q;
  assign init_done   = done_q;
  assign init_err    = err_q;
  assign stream_vld  = svld_q;
  assign stream_data = sdata_q;
  assign retry_cnt   = retry_q;

endmodule
